// File: rtl/montgomery_mult_param.sv
// rtl/montgomery_mult_param.sv - parametrised radix-2 Montgomery multiplier, result = A*B*2^-WIDTH mod M
module montgomery_mult_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             no_reduce,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  typedef enum logic [1:0] {IDLE, ITER, REDUCE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             nr_q;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH:0]   c_next;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // T is kept WIDTH+2 bits wide so C + B + M never wraps before the halving.
  always_comb begin
    t_add  = {1'b0, c_q} + (a_q[0] ? {2'b00, b_q} : '0);
    c_next = (WIDTH + 1)'((t_add + (t_add[0] ? {2'b00, m_q} : '0)) >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (last_iter) state_next = REDUCE;
      REDUCE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      cnt_q  <= '0;
      nr_q   <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            nr_q  <= no_reduce;
            c_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
          end
        end
        ITER: begin
          c_q   <= c_next;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        REDUCE: begin
          // C < 2M, so a single conditional subtraction fully reduces it.
          if (!nr_q && (c_q >= {1'b0, m_q})) result <= c_q - {1'b0, m_q};
          else                               result <= c_q;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// tb/tb_montgomery_mult_param.sv - self-checking bench for montgomery_mult_param (WIDTH=8 and WIDTH=512)
module tb_montgomery_mult_param;

  localparam int W8  = 8;
  localparam int WW  = 512;
  localparam int NRAND = 2500;

  logic          clk;
  logic          reset;
  logic          start8, nr8, busy8, done8;
  logic [W8-1:0] a8, b8, m8;
  logic [W8:0]   res8;
  logic          startw, nrw, busyw, donew;
  logic [WW-1:0] aw, bw, mw;
  logic [WW:0]   resw;

  int checks;
  int errors;

  montgomery_mult_param #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .no_reduce(nr8),
    .in_a(a8), .in_b(b8), .in_m(m8),
    .busy(busy8), .done(done8), .result(res8)
  );

  montgomery_mult_param #(.WIDTH(WW)) dutw (
    .clk(clk), .reset(reset), .start(startw), .no_reduce(nrw),
    .in_a(aw), .in_b(bw), .in_m(mw),
    .busy(busyw), .done(donew), .result(resw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the unique r in [0,M) with r*2^8 == A*B (mod M), found by search.
  function automatic int ref8(input int a, input int b, input int m);
    for (int r = 0; r < m; r++)
      if (((r * 256) % m) == ((a * b) % m)) return r;
    return -1;
  endfunction

  function automatic logic [WW-1:0] rnd512();
    logic [WW-1:0] v;
    for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Pulses start (DUT must be idle), scrambles inputs after acceptance, waits for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                      input logic nr, output logic [8:0] r, output int lat);
    a8 = a; b8 = b; m8 = m; nr8 = nr; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom); nr8 = 1'($urandom);
    lat = 1;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!done8) lat = -1;
    r = res8;
  endtask

  task automatic test_reset();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 9'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b result=%0d, required 0 0 0", busy8, done8, res8);
    end
    checks++;
    if (busyw !== 1'b0 || donew !== 1'b0 || resw !== '0) begin
      errors++;
      $display("FAIL reset512: busy=%b done=%b result=%0h, required 0 0 0", busyw, donew, resw);
    end
  endtask

  task automatic test_known();
    logic [8:0] r;
    int lat;
    run8(8'd5, 8'd7, 8'd13, 1'b0, r, lat);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL known_lat: got %0d, required 10", lat); end
    checks++;
    if (r !== 9'd1) begin errors++; $display("FAIL known_5x7: got %0d, required 1", r); end
    run8(8'd12, 8'd12, 8'd13, 1'b0, r, lat);
    checks++;
    if (r !== 9'd3) begin errors++; $display("FAIL known_12x12: got %0d, required 3", r); end
    run8(8'd0, 8'd9, 8'd13, 1'b0, r, lat);
    checks++;
    if (r !== 9'd0) begin errors++; $display("FAIL known_0x9: got %0d, required 0", r); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b, required 0", busy8); end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL after_done: busy=%b done=%b, required 0 0", busy8, done8);
    end
  endtask

  task automatic test_random();
    logic [8:0] r;
    int lat, m, a, b, nr, exp_r, n_nr0, n_nr1, n_big;
    n_nr0 = 0; n_nr1 = 0; n_big = 0;
    for (int i = 0; i < NRAND; i++) begin
      m  = int'($urandom_range(1, 255)) | 1;
      a  = int'($urandom % 32'(m));
      b  = int'($urandom % 32'(m));
      nr = int'($urandom & 1);
      exp_r = ref8(a, b, m);
      run8(8'(a), 8'(b), 8'(m), 1'(nr), r, lat);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL rand_lat: got %0d, required 10", lat); end
      checks++;
      if (nr == 0) begin
        n_nr0++;
        if (r !== 9'(exp_r)) begin
          errors++;
          $display("FAIL rand_reduced: A=%0d B=%0d M=%0d got %0d, required %0d", a, b, m, r, exp_r);
        end
      end else begin
        n_nr1++;
        if (int'(r) >= m) n_big++;
        if (int'(r) >= 2 * m || (int'(r) % m) != exp_r) begin
          errors++;
          $display("FAIL rand_raw: A=%0d B=%0d M=%0d got %0d, required <%0d and ==%0d mod M",
                   a, b, m, r, 2 * m, exp_r);
        end
      end
    end
    checks++;
    if (n_nr0 == 0 || n_nr1 == 0 || n_big == 0) begin
      errors++;
      $display("FAIL rand_coverage: nr0=%0d nr1=%0d raw_ge_m=%0d, required all nonzero", n_nr0, n_nr1, n_big);
    end
  endtask

  task automatic test_ignore_start();
    int dones, first_done;
    logic [8:0] r;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; nr8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dones = 0; first_done = -1; r = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done8) begin
        dones++;
        if (first_done < 0) begin first_done = cyc; r = res8; end
      end
      if (cyc == 3) begin start8 = 1'b1; a8 = 8'd12; b8 = 8'd12; m8 = 8'd11; nr8 = 1'b1; end
      if (cyc == 4) start8 = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (first_done !== 10) begin errors++; $display("FAIL ignore_lat: got %0d, required 10", first_done); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL ignore_dones: got %0d, required 1", dones); end
    checks++;
    if (r !== 9'd1) begin errors++; $display("FAIL ignore_result: got %0d, required 1", r); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] r;
    int lat, dones;
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; nr8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy8); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%0d, required 0 0 0", busy8, done8, res8);
    end
    dones = 0;
    repeat (14) begin @(posedge clk); #1; if (done8) dones++; end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses, required 0", dones); end
    run8(8'd5, 8'd7, 8'd13, 1'b0, r, lat);
    checks++;
    if (lat !== 10 || r !== 9'd1) begin
      errors++; $display("FAIL mid_restart: lat=%0d result=%0d, required 10 1", lat, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; nr8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd12; b8 = 8'd12;
    lat = 1;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 10 || res8 !== 9'd1) begin
      errors++; $display("FAIL b2b_first: lat=%0d result=%0d, required 10 1", lat, res8);
    end
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy8); end
    lat = 1;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 10 || res8 !== 9'd3) begin
      errors++; $display("FAIL b2b_second: lat=%0d result=%0d, required 10 3", lat, res8);
    end
  endtask

  task automatic test_wide();
    logic [WW-1:0] ma [2];
    logic [WW-1:0] aa [2];
    logic [WW-1:0] ba [2];
    logic [1039:0] lhs, rhs;
    int lat;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 2; k++) begin
        ma[k] = rnd512() | {1'b1, {(WW-2){1'b0}}, 1'b1};
        aa[k] = rnd512() % ma[k];
        ba[k] = rnd512() % ma[k];
      end
      // n==2 holds start high through the first operation to get a back-to-back pair.
      aw = aa[0]; bw = ba[0]; mw = ma[0]; nrw = 1'b0; startw = 1'b1;
      @(posedge clk); #1;
      if (n != 2) startw = 1'b0;
      aw = aa[1]; bw = ba[1]; mw = ma[1];
      for (int k = 0; k < (n == 2 ? 2 : 1); k++) begin
        if (k == 1) begin @(posedge clk); #1; startw = 1'b0; end
        lat = 1;
        while (!donew && lat < 600) begin @(posedge clk); #1; lat++; end
        lhs = ({527'd0, resw} << WW) % {528'd0, ma[k]};
        rhs = ({528'd0, aa[k]} * {528'd0, ba[k]}) % {528'd0, ma[k]};
        checks++;
        if (lat !== WW + 2) begin
          errors++; $display("FAIL wide_lat[%0d.%0d]: got %0d, required %0d", n, k, lat, WW + 2);
        end
        checks++;
        if (resw >= {1'b0, ma[k]} || lhs !== rhs) begin
          errors++;
          $display("FAIL wide_result[%0d.%0d]: got %0h, required r<M with r*2^512==A*B mod M", n, k, resw);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    start8 = 1'b0; nr8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    startw = 1'b0; nrw = 1'b0; aw = '0; bw = '0; mw = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_known();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
